// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock: mode and cursor encodings plus
// the BCD digit maxima. Used by time_keeper and by the display driver.
package clock_pkg;

  typedef enum logic [1:0] {
    SETUP   = 2'b00,
    TIME24  = 2'b01,
    SECONDS = 2'b10,
    TIME12  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    FIRSTDIGIT  = 2'd0,
    SECONDDIGIT = 2'd1,
    THIRDDIGIT  = 2'd2,
    FOURTHDIGIT = 2'd3
  } cursor_e;

  // Largest legal value of each kind of digit field
  localparam logic [2:0] TENS_MAX             = 3'd5;
  localparam logic [3:0] UNITS_MAX            = 4'd9;
  localparam logic [1:0] HOUR_TENS_MAX        = 2'd2;
  localparam logic [3:0] HOUR_UNITS_MAX_AT_20 = 4'd3;

endpackage

// File: rtl/sec_prescaler.sv
// Divides clk down to a once-per-second strobe and an optional blink wave.
// sec_tick is a single-cycle strobe decoded from the counter register; the
// consumer registers it so that its own time update lands on the same edge.
// Optional feature macro: TIME_KEEPER_BLINK_EN (free-running counter + blink).
module sec_prescaler #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold,
  output logic sec_tick,
  output logic blink
);

  localparam int             CW   = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0]  LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: held at zero while hold is asserted, otherwise wraps at LAST
  always_comb begin
    cnt_d = cnt_q;
    if (hold) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Prescaler counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sec_tick = !hold && (cnt_q == LAST);

`ifdef TIME_KEEPER_BLINK_EN
  localparam logic [CW-1:0] HALF = CW'(CLK_HZ / 2 - 1);

  logic [CW-1:0] free_q;
  logic [CW-1:0] free_d;
  logic          blink_q;
  logic          blink_d;

  // Free-running copy of the counter keeps blink alive during setup
  always_comb begin
    free_d  = free_q;
    blink_d = blink_q;
    if (free_q == LAST) begin
      free_d = '0;
    end else begin
      free_d = free_q + CW'(1);
    end
    if ((free_q == HALF) || (free_q == LAST)) begin
      blink_d = ~blink_q;
    end else begin
      blink_d = blink_q;
    end
  end

  // Free counter and blink registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      free_q  <= '0;
      blink_q <= 1'b0;
    end else begin
      free_q  <= free_d;
      blink_q <= blink_d;
    end
  end

  assign blink = blink_q;
`else
  assign blink = 1'b0;
`endif

endmodule

// File: rtl/time_keeper.sv
// Time-of-day counter with BCD fields and two-button time setup.
// Optional feature macro: TIME_KEEPER_BLINK_EN (enables the blink output).
module time_keeper
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic       btn_next,
  input  logic       btn_inc,
  output logic [3:0] secondsLower,
  output logic [2:0] secondsUpper,
  output logic [3:0] minutesLower,
  output logic [2:0] minutesUpper,
  output logic [3:0] hoursLower,
  output logic [1:0] hoursUpper,
  output logic [1:0] location,
  output logic       sec_tick,
  output logic       blink
);

  logic       hold_s, tick_s, next_rise_s, inc_rise_s;
  logic [3:0] sl_q, sl_d, ml_q, ml_d, hl_q, hl_d;
  logic [2:0] su_q, su_d, mu_q, mu_d;
  logic [1:0] hu_q, hu_d, loc_q, loc_d;
  logic       tick_q, tick_d, next_hist_q, inc_hist_q;

  assign hold_s      = (mode == SETUP);
  assign next_rise_s = btn_next && !next_hist_q;
  assign inc_rise_s  = btn_inc && !inc_hist_q;

  sec_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .hold     (hold_s),
    .sec_tick (tick_s),
    .blink    (blink)
  );

  // Next-state: BCD carry chain in run modes, per-digit editing in setup
  always_comb begin
    sl_d = sl_q; su_d = su_q; ml_d = ml_q; mu_d = mu_q;
    hl_d = hl_q; hu_d = hu_q; loc_d = loc_q; tick_d = 1'b0;
    if (hold_s) begin
      sl_d = 4'd0;
      su_d = 3'd0;
      if (inc_rise_s) begin
        case (loc_q)
          FIRSTDIGIT: begin
            if (hu_q == HOUR_TENS_MAX) begin
              hu_d = 2'd0;
            end else begin
              hu_d = hu_q + 2'd1;
              if ((hu_d == HOUR_TENS_MAX) && (hl_q > HOUR_UNITS_MAX_AT_20)) begin
                hl_d = HOUR_UNITS_MAX_AT_20;
              end else begin
                hl_d = hl_q;
              end
            end
          end
          SECONDDIGIT: begin
            if (hu_q == HOUR_TENS_MAX) begin
              hl_d = (hl_q >= HOUR_UNITS_MAX_AT_20) ? 4'd0 : hl_q + 4'd1;
            end else begin
              hl_d = (hl_q >= UNITS_MAX) ? 4'd0 : hl_q + 4'd1;
            end
          end
          THIRDDIGIT:  mu_d = (mu_q >= TENS_MAX) ? 3'd0 : mu_q + 3'd1;
          FOURTHDIGIT: ml_d = (ml_q >= UNITS_MAX) ? 4'd0 : ml_q + 4'd1;
          default:     ml_d = ml_q;
        endcase
      end else begin
        hu_d = hu_q;
      end
      if (next_rise_s) begin
        loc_d = loc_q + 2'd1;
      end else begin
        loc_d = loc_q;
      end
    end else begin
      tick_d = tick_s;
      if (!tick_s) begin
        sl_d = sl_q;
      end else if (sl_q < UNITS_MAX) begin
        sl_d = sl_q + 4'd1;
      end else begin
        sl_d = 4'd0;
        if (su_q < TENS_MAX) begin
          su_d = su_q + 3'd1;
        end else begin
          su_d = 3'd0;
          if (ml_q < UNITS_MAX) begin
            ml_d = ml_q + 4'd1;
          end else begin
            ml_d = 4'd0;
            if (mu_q < TENS_MAX) begin
              mu_d = mu_q + 3'd1;
            end else begin
              mu_d = 3'd0;
              if ((hu_q == HOUR_TENS_MAX) && (hl_q >= HOUR_UNITS_MAX_AT_20)) begin
                hu_d = 2'd0;
                hl_d = 4'd0;
              end else if (hl_q >= UNITS_MAX) begin
                hu_d = hu_q + 2'd1;
                hl_d = 4'd0;
              end else begin
                hl_d = hl_q + 4'd1;
              end
            end
          end
        end
      end
    end
  end

  // Time, cursor, tick and button-history registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sl_q <= 4'd0; su_q <= 3'd0; ml_q <= 4'd0; mu_q <= 3'd0;
      hl_q <= 4'd0; hu_q <= 2'd0; loc_q <= 2'd0; tick_q <= 1'b0;
      next_hist_q <= 1'b0; inc_hist_q <= 1'b0;
    end else begin
      sl_q <= sl_d; su_q <= su_d; ml_q <= ml_d; mu_q <= mu_d;
      hl_q <= hl_d; hu_q <= hu_d; loc_q <= loc_d; tick_q <= tick_d;
      next_hist_q <= btn_next; inc_hist_q <= btn_inc;
    end
  end

  assign secondsLower = sl_q;
  assign secondsUpper = su_q;
  assign minutesLower = ml_q;
  assign minutesUpper = mu_q;
  assign hoursLower   = hl_q;
  assign hoursUpper   = hu_q;
  assign location     = loc_q;
  assign sec_tick     = tick_q;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper with a time-of-day reference model.
module tb_time_keeper;

  localparam int CLK_HZ = 4;

  logic       clk = 1'b0;
  logic       rst_n, btn_next, btn_inc;
  logic [1:0] mode;
  logic [3:0] secondsLower, minutesLower, hoursLower;
  logic [2:0] secondsUpper, minutesUpper;
  logic [1:0] hoursUpper, location;
  logic       sec_tick, blink;

  time_keeper #(.CLK_HZ(CLK_HZ)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .btn_next(btn_next), .btn_inc(btn_inc),
    .secondsLower(secondsLower), .secondsUpper(secondsUpper),
    .minutesLower(minutesLower), .minutesUpper(minutesUpper),
    .hoursLower(hoursLower), .hoursUpper(hoursUpper),
    .location(location), .sec_tick(sec_tick), .blink(blink)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Reference model: time as integer hours/minutes/seconds
  int m_hh, m_mm, m_ss, m_loc, m_run, m_k;
  bit m_tick, m_blink, m_pn, m_pi;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_edge();
    int t, u, total;
    bit nr, ir;
    if (!rst_n) begin
      m_hh = 0; m_mm = 0; m_ss = 0; m_loc = 0; m_run = 0; m_k = 0;
      m_tick = 0; m_blink = 0; m_pn = 0; m_pi = 0;
    end else begin
      m_k++;
`ifdef TIME_KEEPER_BLINK_EN
      m_blink = ((m_k / (CLK_HZ / 2)) % 2) == 1;
`else
      m_blink = 0;
`endif
      nr = btn_next && !m_pn;
      ir = btn_inc && !m_pi;
      m_pn = btn_next;
      m_pi = btn_inc;
      if (mode == 2'b00) begin
        m_ss = 0; m_tick = 0; m_run = 0;
        if (ir) begin
          t = m_hh / 10; u = m_hh % 10;
          case (m_loc)
            0: begin t = (t + 1) % 3; if (t == 2 && u > 3) u = 3; m_hh = t * 10 + u; end
            1: begin u = (u + 1) % ((t == 2) ? 4 : 10); m_hh = t * 10 + u; end
            2: m_mm = ((m_mm / 10 + 1) % 6) * 10 + m_mm % 10;
            default: m_mm = (m_mm / 10) * 10 + (m_mm % 10 + 1) % 10;
          endcase
        end
        if (nr) m_loc = (m_loc + 1) % 4;
      end else begin
        m_run++;
        m_tick = 0;
        if (m_run == CLK_HZ) begin
          m_run = 0;
          m_tick = 1;
          total = (m_hh * 3600 + m_mm * 60 + m_ss + 1) % 86400;
          m_hh = total / 3600; m_mm = (total / 60) % 60; m_ss = total % 60;
        end
      end
    end
  endtask

  // Compare all outputs against the model on every falling edge
  always @(negedge clk) begin
    if (check_en) begin
      chk("secondsLower", int'(secondsLower), m_ss % 10);
      chk("secondsUpper", int'(secondsUpper), m_ss / 10);
      chk("minutesLower", int'(minutesLower), m_mm % 10);
      chk("minutesUpper", int'(minutesUpper), m_mm / 10);
      chk("hoursLower", int'(hoursLower), m_hh % 10);
      chk("hoursUpper", int'(hoursUpper), m_hh / 10);
      chk("location", int'(location), m_loc);
      chk("sec_tick", int'(sec_tick), int'(m_tick));
      chk("blink", int'(blink), int'(m_blink));
    end
  end

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic press(input bit n, input bit i);
    btn_next = n; btn_inc = i;
    step();
    btn_next = 1'b0; btn_inc = 1'b0;
    step();
  endtask

  function automatic int hours_now();
    return int'(hoursUpper) * 10 + int'(hoursLower);
  endfunction

  function automatic int minutes_now();
    return int'(minutesUpper) * 10 + int'(minutesLower);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    bit found;
    bit prev;
    rst_n = 1'b0; mode = 2'b01; btn_next = 1'b0; btn_inc = 1'b0;
    @(posedge clk);
    model_edge();
    check_en = 1'b1;
    @(negedge clk);
    #1;
    step(); step();
    chk("reset_all_zero", int'({secondsLower, secondsUpper, minutesLower, minutesUpper,
                                hoursLower, hoursUpper, location, sec_tick, blink}), 0);

    // Run 12 cycles in TIME24: three ticks, seconds at 03
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (sec_tick) n++;
    end
    chk("ticks_in_12", n, 3);
    chk("seconds_after_12", int'(secondsLower), 3);

    // Setup clears seconds and suppresses ticks
    mode = 2'b00;
    step();
    chk("setup_clears_sec", int'(secondsUpper) * 10 + int'(secondsLower), 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (sec_tick) n++;
    end
    chk("setup_no_tick", n, 0);

    // First tick after leaving setup arrives CLK_HZ cycles later
    mode = 2'b01;
    n = 0; found = 1'b0;
    for (int i = 1; i <= 10 && !found; i++) begin
      step();
      if (sec_tick) begin found = 1'b1; n = i; end
    end
    chk("first_tick_latency", n, 4);

    // Set 23:59 via the buttons
    mode = 2'b00;
    step();
    repeat (2) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    repeat (3) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    repeat (5) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    repeat (9) press(1'b0, 1'b1);
    chk("set_hours_23", hours_now(), 23);
    chk("set_minutes_59", minutes_now(), 59);
    chk("set_loc_3", int'(location), 3);

    // Simultaneous rising edges, then held buttons
    btn_next = 1'b1; btn_inc = 1'b1;
    step();
    chk("both_minutes", minutes_now(), 50);
    chk("both_loc", int'(location), 0);
    repeat (10) step();
    chk("held_minutes", minutes_now(), 50);
    chk("held_loc", int'(location), 0);
    btn_next = 1'b0; btn_inc = 1'b0;
    step();

    // Back to 23:59 then run 60 ticks to midnight
    repeat (3) press(1'b1, 1'b0);
    repeat (9) press(1'b0, 1'b1);
    chk("reset_minutes_59", minutes_now(), 59);
    mode = 2'b01;
    repeat (240) step();
    chk("rollover_hours", hours_now(), 0);
    chk("rollover_minutes", minutes_now(), 0);
    chk("rollover_seconds", int'(secondsUpper) * 10 + int'(secondsLower), 0);
    chk("rollover_tick", int'(sec_tick), 1);

    // Clamp: 19 -> 23 -> 03 through the hours tens digit
    mode = 2'b00;
    step();
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    repeat (9) press(1'b0, 1'b1);
    chk("hours_19", hours_now(), 19);
    repeat (3) press(1'b1, 1'b0);
    chk("clamp_loc_0", int'(location), 0);
    press(1'b0, 1'b1);
    chk("clamp_hours_23", hours_now(), 23);
    press(1'b0, 1'b1);
    chk("clamp_hours_03", hours_now(), 3);

    // Blink activity over 8 cycles while in setup
    prev = blink;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (blink != prev) n++;
      prev = blink;
    end
`ifdef TIME_KEEPER_BLINK_EN
    chk("blink_toggles", n, 4);
`else
    chk("blink_toggles", n, 0);
`endif

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_keeper.md
# time_keeper

Time-of-day counter for the digital clock. Derives a 1 Hz tick from `clk`, keeps hours, minutes and seconds as BCD digit fields, and lets the user set the time in setup mode with two buttons. It sits directly upstream of the seven-segment display driver and feeds it every digit field plus the setup cursor `location`.

## Interface
- `CLK_HZ`, default 50_000_000: input clock frequency; the prescaler period in cycles. Minimum 2.
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `mode` input 2: 00 SETUP, 01 TIME24, 10 SECONDS, 11 TIME12.
- `btn_next` input 1: advance setup cursor. Already synchronised and debounced, level.
- `btn_inc` input 1: increment the digit under the cursor. Already synchronised and debounced, level.
- `secondsLower` output 4: seconds units, 0–9.
- `secondsUpper` output 3: seconds tens, 0–5.
- `minutesLower` output 4: minutes units, 0–9.
- `minutesUpper` output 3: minutes tens, 0–5.
- `hoursLower` output 4: hours units, 0–9.
- `hoursUpper` output 2: hours tens, 0–2.
- `location` output 2: setup cursor. 0 = hoursUpper, 1 = hoursLower, 2 = minutesUpper, 3 = minutesLower.
- `sec_tick` output 1: one-cycle pulse, once per second.
- `blink` output 1: half-second square wave; see Configuration.

## Operation
- Reset (`rst_n`=0 at a clock edge) forces every output and every internal register to 0, giving 00:00:00 with `location`=0. Reset mid-count or mid-setup behaves the same.
- **Prescaler**
  - `cnt` counts 0..CLK_HZ-1 and wraps to 0.
  - `sec_tick` is asserted in the cycle after `cnt` reaches CLK_HZ-1.
  - While `mode`=SETUP, `cnt` is held at 0 and `sec_tick` is 0.
- **Run states** (`mode` ≠ SETUP; TIME24, SECONDS and TIME12 all count the same way)
  - On each `sec_tick`, seconds advance by 1 with BCD carry: secondsLower 9→0 carries into secondsUpper; 59→00 carries into minutes; minutes 59→00 carries into hours.
  - Hours wrap 23→00, so 23:59:59 → 00:00:00.
  - Buttons are ignored and `location` holds its value.
- **SETUP state**
  - On the first SETUP cycle, seconds are cleared to 00.
  - No carries occur between fields.
  - A rising edge on `btn_next` (btn=1 at this edge, 0 at the previous edge) advances `location` 0→1→2→3→0.
  - A rising edge on `btn_inc` increments the digit selected by `location`, with wrap:
    - loc 0: hoursUpper 0→1→2→0. When it becomes 2 and hoursLower > 3, hoursLower is clamped to 3 in the same cycle.
    - loc 1: hoursLower wraps after 9, or after 3 when hoursUpper = 2.
    - loc 2: minutesUpper wraps after 5.
    - loc 3: minutesLower wraps after 9.
  - If both buttons rise at the same edge, the increment applies to the old `location` and `location` advances at that same edge.
  - A held button produces exactly one action.
- **Leaving SETUP**: the prescaler restarts from 0, so the first tick arrives CLK_HZ cycles later. Edge-detect history keeps updating in all modes, so a button held across the mode change does not fire.
- Digit fields never hold an out-of-range value in any state.

## Timing
- All outputs are registered.
- Button action becomes visible on the outputs after the clock edge at which the rising edge is detected: one cycle after the input is first sampled high.
- Time fields update at the same edge that `sec_tick` is registered high. The driver sees the new time while `sec_tick`=1.
- Tick period: exactly CLK_HZ cycles in steady run.

## Configuration
- `TIME_KEEPER_BLINK_EN` defined:
  - `blink` toggles whenever `cnt` equals CLK_HZ/2-1 or CLK_HZ-1, giving a 1 Hz, roughly 50 % duty wave.
  - In SETUP, `blink` keeps toggling from a free-running copy of the counter.
  - Reset value of `blink` is 0.
- Not defined: `blink` is tied to 0 and the free-running counter is absent.

## Structure
- Shared package `clock_pkg` holds:
  - mode encodings SETUP/TIME24/SECONDS/TIME12;
  - cursor encodings FIRSTDIGIT..FOURTHDIGIT;
  - digit maxima (5, 9, 2, 3).
- The display driver reuses the same package.
- One sub-module: `sec_prescaler`, with parameter CLK_HZ, inputs `clk`, `rst_n` and `hold`, and outputs `sec_tick` and `blink`.
- Counting and setup logic live in `time_keeper`.

## Test plan
All scenarios use CLK_HZ=4.
- Reset: hold `rst_n`=0 for 3 cycles. All outputs are 0. Release and run in TIME24: `sec_tick` pulses every 4 cycles and seconds reach 03 after 12 cycles.
- Rollover: set 23:59, then switch to TIME24 and run 240 cycles (60 ticks). Outputs read 00:00:00 and `sec_tick` stays periodic.
- Setup clamp: set hours to 19, put `location`=0, pulse `btn_inc`. Hours become 29? No: 19→29 is not allowed; the result is hoursUpper=2, hoursLower=3 (23). Pulse `btn_inc` again: hoursUpper=0, hours 03.
- Cursor and simultaneous buttons: `location`=3, minutesLower=9, raise `btn_next` and `btn_inc` at the same edge. minutesLower=0 and `location`=0. Hold both high for 10 cycles: no further change.
- Mode switch: run to 00:00:02, enter SETUP. Seconds become 00 and no `sec_tick` appears for 20 cycles. Return to TIME24: the first tick comes 4 cycles later.
- With `TIME_KEEPER_BLINK_EN`: `blink` toggles every 2 cycles, including while in SETUP. Without it, `blink` stays 0.
